mod100_bcd_display: RTL and testbench

Display-side consumer for the 7-bit mod-100 count value. It accepts a binary value 0–99 on a load strobe and converts it to two BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives a time-multiplexed two-digit 7-segment display from the latched digits. It sits between the mod-100 counter and the board display pins.

---
 rtl/mod100_bcd_display.sv | 132 +++++++++++++
 tb/tb_mod100_bcd_display.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod100_bcd_display.sv
// Converts a 0-99 binary count to two BCD digits with a 7-step shift-add-3 engine and
// drives a two-digit multiplexed 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module mod100_bcd_display #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] count_in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg,
    output logic [1:0] digit_en
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_reg, state_next;
    logic [14:0]   work_reg;          // {bcd[7:0], bin[6:0]}
    logic [14:0]   work_next;
    logic [7:0]    bcd_adj;
    logic [2:0]    iter_reg;
    logic [3:0]    tens_reg, ones_reg;
    logic          err_reg;
    logic [CW-1:0] refresh_reg;
    logic [1:0]    digit_en_reg;
    logic          accept;
    logic [6:0]    sat_in;
    logic [3:0]    digit_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (work_reg[7 + gi*4 +: 4] >= 4'd5)
                                      ? work_reg[7 + gi*4 +: 4] + 4'd3
                                      : work_reg[7 + gi*4 +: 4];
        end
    endgenerate

    assign work_next = {bcd_adj, work_reg[6:0]} << 1;
    assign accept    = load && (state_reg != SHIFT);
    assign sat_in    = (count_in >= 7'd100) ? 7'd99 : count_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: state_next = load ? SHIFT : IDLE;
            SHIFT:      if (iter_reg == 3'd6) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == SHIFT);
        done = (state_reg == DONE);
    end

    // Result registers only move on the final iteration, so the display never shows partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg <= '0;
            iter_reg <= '0;
            tens_reg <= '0;
            ones_reg <= '0;
            err_reg  <= 1'b0;
        end else if (accept) begin
            work_reg <= {8'd0, sat_in};
            iter_reg <= '0;
            err_reg  <= (count_in >= 7'd100);
        end else if (state_reg == SHIFT) begin
            work_reg <= work_next;
            iter_reg <= iter_reg + 3'd1;
            if (iter_reg == 3'd6) begin
                tens_reg <= work_next[14:11];
                ones_reg <= work_next[10:7];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_reg  <= '0;
            digit_en_reg <= 2'b01;
        end else if (refresh_reg == CW'(REFRESH_DIV - 1)) begin
            refresh_reg  <= '0;
            digit_en_reg <= {digit_en_reg[0], digit_en_reg[1]};
        end else begin
            refresh_reg  <= refresh_reg + CW'(1);
        end
    end

    assign digit_sel = digit_en_reg[1] ? tens_reg : ones_reg;

    always_comb begin
        case (digit_sel)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (digit_en_reg[1] && (tens_reg == 4'd0)) seg = 7'h00;
`else
`endif
    end

    assign tens     = tens_reg;
    assign ones     = ones_reg;
    assign err      = err_reg;
    assign digit_en = digit_en_reg;

endmodule

// File: tb/tb_mod100_bcd_display.sv
// Directed self-checking bench for mod100_bcd_display with a short refresh period.
module tb_mod100_bcd_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] count_in = 7'd0;
    logic       load = 1'b0;
    logic       busy, done, err;
    logic [3:0] tens, ones;
    logic [6:0] seg;
    logic [1:0] digit_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod100_bcd_display #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .load(load),
        .busy(busy), .done(done), .err(err), .tens(tens), .ones(ones),
        .seg(seg), .digit_en(digit_en)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({tens, ones, busy, done, err} !== 11'd0) begin
            n_bad++;
            $display("FAIL %s_regs: got t=%0d o=%0d b=%b d=%b e=%b expected all zero", tag, tens, ones, busy, done, err);
        end
        n_cmp++;
        if (seg !== 7'h3F) begin
            n_bad++;
            $display("FAIL %s_seg: got %h expected 3f", tag, seg);
        end
        n_cmp++;
        if (digit_en !== 2'b01) begin
            n_bad++;
            $display("FAIL %s_digit_en: got %b expected 01", tag, digit_en);
        end
    endtask

    task automatic test_reset;
        int k;
        rst = 1'b1; load = 1'b0; count_in = 7'd0;
        step; step;
        check_reset_values("reset");
        rst = 1'b0;
        k = 0;
        while (digit_en === 2'b01 && k < 20) begin step; k++; end
        n_cmp++;
        if (k !== RD || digit_en !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_first_toggle: got %0d cycles (digit_en=%b) expected %0d (10)", k, digit_en, RD);
        end
        $display("reset: first digit toggle after %0d cycles", k);
    endtask

    // Loads v and runs to the done cycle; optionally steps past it to confirm a single-cycle pulse.
    task automatic convert(input logic [6:0] v, input logic [3:0] et, input logic [3:0] eo,
                           input logic ee, input bit stay_in_done, input string tag);
        logic [3:0] old_t, old_o;
        int n;
        bit held;
        old_t = tens; old_o = ones;
        count_in = v; load = 1'b1;
        step;
        load = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_busy_start: got %b expected 1", tag, busy);
        end
        n = 0; held = 1'b1;
        while (busy === 1'b1 && n < 20) begin
            if (tens !== old_t || ones !== old_o) held = 1'b0;
            step; n++;
        end
        n_cmp++;
        if (n !== 7) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d busy cycles expected 7", tag, n);
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_hold: digits changed during conversion, expected %0d/%0d held", tag, old_t, old_o);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: got %b expected 1", tag, done);
        end
        n_cmp++;
        if (tens !== et || ones !== eo || err !== ee) begin
            n_bad++;
            $display("FAIL %s_result: got %0d/%0d err=%b expected %0d/%0d err=%b", tag, tens, ones, err, et, eo, ee);
        end
        $display("convert %s: in=%0d -> tens=%0d ones=%0d err=%b latency=%0d", tag, v, tens, ones, err, n);
        if (!stay_in_done) begin
            step;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_done_width: got done=%b busy=%b expected 0/0", tag, done, busy);
            end
        end
    endtask

    task automatic check_display(input logic [6:0] s_ones, input logic [6:0] s_tens, input string tag);
        int k;
        k = 0;
        while (digit_en !== 2'b01 && k < 12) begin step; k++; end
        n_cmp++;
        if (digit_en !== 2'b01 || seg !== s_ones) begin
            n_bad++;
            $display("FAIL %s_seg_ones: got seg=%h en=%b expected %h en=01", tag, seg, digit_en, s_ones);
        end
        k = 0;
        while (digit_en !== 2'b10 && k < 12) begin step; k++; end
        n_cmp++;
        if (digit_en !== 2'b10 || seg !== s_tens) begin
            n_bad++;
            $display("FAIL %s_seg_tens: got seg=%h en=%b expected %h en=10", tag, seg, digit_en, s_tens);
        end
        k = 0;
        while (digit_en === 2'b10 && k < 12) begin step; k++; end
        n_cmp++;
        if (k !== RD) begin
            n_bad++;
            $display("FAIL %s_period: got %0d cycles expected %0d", tag, k, RD);
        end
        $display("display %s: ones seg=%h tens seg=%h period=%0d", tag, s_ones, s_tens, k);
    endtask

    task automatic test_single;
        convert(7'd57, 4'd5, 4'd7, 1'b0, 1'b0, "c57");
        check_display(7'h07, 7'h6D, "d57");
    endtask

    task automatic test_back_to_back;
        int n;
        bit saw_lo, saw_hi, seg_ok;
        convert(7'd99, 4'd9, 4'd9, 1'b0, 1'b1, "c99");
        count_in = 7'd0; load = 1'b1;
        step;
        load = 1'b0;
        n = 0; saw_lo = 1'b0; saw_hi = 1'b0; seg_ok = 1'b1;
        while (busy === 1'b1 && n < 20) begin
            if (digit_en === 2'b01) saw_lo = 1'b1;
            if (digit_en === 2'b10) saw_hi = 1'b1;
            if (seg !== 7'h6F) seg_ok = 1'b0;
            step; n++;
        end
        n_cmp++;
        if (n + 1 !== 8) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d cycles between done pulses expected 8", n + 1);
        end
        n_cmp++;
        if (!(saw_lo && saw_hi && seg_ok)) begin
            n_bad++;
            $display("FAIL b2b_seg99: got lo=%b hi=%b seg_ok=%b expected both digits 6f", saw_lo, saw_hi, seg_ok);
        end
        n_cmp++;
        if (done !== 1'b1 || tens !== 4'd0 || ones !== 4'd0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_result: got done=%b %0d/%0d err=%b expected 1 0/0 0", done, tens, ones, err);
        end
        $display("convert b2b: in=0 -> tens=%0d ones=%0d spacing=%0d", tens, ones, n + 1);
        step;
    endtask

    task automatic test_out_of_range;
        convert(7'd120, 4'd9, 4'd9, 1'b1, 1'b0, "c120");
        convert(7'd3, 4'd0, 4'd3, 1'b0, 1'b0, "c3");
    endtask

    task automatic test_ignored_load;
        int n;
        bit busy_seen;
        count_in = 7'd25; load = 1'b1;
        step;
        load = 1'b0;
        step;
        count_in = 7'd42; load = 1'b1;
        step;
        count_in = 7'd110;
        step;
        load = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin step; n++; end
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL ign_latency: got %0d extra cycles expected 4", n);
        end
        n_cmp++;
        if (tens !== 4'd2 || ones !== 4'd5 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_result: got %0d/%0d err=%b expected 2/5 err=0", tens, ones, err);
        end
        busy_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (busy === 1'b1 || done === 1'b1) busy_seen = 1'b1;
        end
        n_cmp++;
        if (busy_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_queued: got activity after done expected idle");
        end
        $display("convert ign: in=25 (42,110 ignored) -> tens=%0d ones=%0d", tens, ones);
    endtask

    task automatic test_abort;
        bit done_seen;
        count_in = 7'd120; load = 1'b1;
        step;
        load = 1'b0;
        step; step; step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        check_reset_values("abort");
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step;
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        n_cmp++;
        if (done_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: got activity after reset expected none");
        end
        $display("abort: reset during shift, tens=%0d ones=%0d", tens, ones);
    endtask

    task automatic test_leading_zero;
        logic [6:0] tens_blank;
`ifdef LEADING_ZERO_BLANK_EN
        tens_blank = 7'h00;
`else
        tens_blank = 7'h3F;
`endif
        convert(7'd7, 4'd0, 4'd7, 1'b0, 1'b0, "c7");
        check_display(7'h07, tens_blank, "d7");
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_out_of_range;
        test_ignored_load;
        test_abort;
        test_leading_zero;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
